// File: rtl/counter_game_master.sv
// Host-side master for the counter game: loads one configuration, strobes INIT,
// steers ctrl while the game runs, tallies WINNER/LOSER pulses, cross-checks the
// reported WHO against those tallies and reports the outcome with a done pulse.
module counter_game_master #(
   parameter int unsigned COUNTER_SIZE   = 4,
   parameter int unsigned TALLY_MAX      = 15,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_l,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [COUNTER_SIZE-1:0] cmd_load,
   input  logic [1:0]              cmd_ctrl,
   input  logic                    cmd_bounce,
   input  logic                    abort,
   output logic                    INIT,
   output logic [COUNTER_SIZE-1:0] loadValue,
   output logic [1:0]              ctrl,
   input  logic [1:0]              WHO,
   input  logic                    LOSER,
   input  logic                    WINNER,
   input  logic                    GAMEOVER,
   output logic                    done,
   output logic [1:0]              result_who,
   output logic [COUNTER_SIZE-1:0] win_tally,
   output logic [COUNTER_SIZE-1:0] lose_tally,
   output logic                    mismatch,
   output logic                    timeout
);

   localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNTER_SIZE-1:0] TallySat = '1;
   localparam logic [COUNTER_SIZE-1:0] TallyTarget = COUNTER_SIZE'(TALLY_MAX);

   typedef enum logic [1:0] {StIdle, StInitPulse, StRun, StReport} state_e;

   state_e state_q, state_d;

   logic [COUNTER_SIZE-1:0] load_q;
   logic [1:0]              ctrl_q;
   logic                    bounce_q;
   logic [COUNTER_SIZE-1:0] win_q, lose_q;
   logic [1:0]              who_q;
   logic                    mismatch_q;
   logic                    timeout_q;
   logic [WdW-1:0]          wd_q;

   logic [COUNTER_SIZE-1:0] next_win, next_lose;
   logic [1:0]              exp_who;
   logic                    wd_expired;

   // Saturating tally increments and the WHO value the tallies predict.
   always_comb begin
      next_lose = (lose_q == TallySat) ? lose_q : lose_q + COUNTER_SIZE'(LOSER);
      next_win  = (win_q == TallySat) ? win_q : win_q + COUNTER_SIZE'(WINNER);
      exp_who   = 2'b00;
      if (next_lose == TallyTarget) begin
         exp_who = 2'b01;
      end else if (next_win == TallyTarget) begin
         exp_who = 2'b10;
      end
      wd_expired = (wd_q == WdLast);
   end

   // State register.
   always_ff @(posedge clk or posedge rst_l) begin
      if (rst_l) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort outranks GAMEOVER, which outranks the watchdog.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:      if (cmd_valid) state_d = StInitPulse;
         StInitPulse: state_d = abort ? StIdle : StRun;
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else if (GAMEOVER || wd_expired) begin
               state_d = StReport;
            end
         end
         StReport:    state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      cmd_ready = (state_q == StIdle);
      INIT      = (state_q == StInitPulse);
      done      = (state_q == StReport);
   end

   // Game datapath: configuration capture, tallies, WHO check and watchdog.
   always_ff @(posedge clk or posedge rst_l) begin
      if (rst_l) begin
         load_q     <= '0;
         ctrl_q     <= '0;
         bounce_q   <= 1'b0;
         win_q      <= '0;
         lose_q     <= '0;
         who_q      <= '0;
         mismatch_q <= 1'b0;
         timeout_q  <= 1'b0;
         wd_q       <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  load_q     <= cmd_load;
                  ctrl_q     <= cmd_ctrl;
                  bounce_q   <= cmd_bounce;
                  win_q      <= '0;
                  lose_q     <= '0;
                  who_q      <= '0;
                  mismatch_q <= 1'b0;
                  timeout_q  <= 1'b0;
               end
            end
            StInitPulse: begin
               wd_q <= '0;
            end
            StRun: begin
               // An aborted game leaves every result untouched.
               if (!abort) begin
                  win_q  <= next_win;
                  lose_q <= next_lose;
                  wd_q   <= wd_q + WdW'(1);
                  if (LOSER && WINNER) begin
                     mismatch_q <= 1'b1;
                  end
                  if (bounce_q && (LOSER || WINNER)) begin
                     ctrl_q[1] <= ~ctrl_q[1];
                  end
                  if (GAMEOVER) begin
                     who_q <= WHO;
                     if (WHO != exp_who) begin
                        mismatch_q <= 1'b1;
                     end
                  end else if (wd_expired) begin
                     timeout_q <= 1'b1;
                     who_q     <= 2'b00;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign loadValue  = load_q;
   assign ctrl       = ctrl_q;
   assign result_who = who_q;
   assign win_tally  = win_q;
   assign lose_tally = lose_q;
   assign mismatch   = mismatch_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_counter_game_master.sv
// Bench for counter_game_master: a table of game configurations played against a
// behavioural counter model, plus hand-written abort, reset, saturation, double
// pulse and watchdog sequences. Results are checked through an expected-result queue.
module tb_counter_game_master;

   typedef struct {
      logic [3:0] load;
      logic [1:0] mode;
      logic       bounce;
      logic       lie;
      logic [1:0] who;
      logic [3:0] win;
      logic [3:0] lose;
      logic       mm;
      logic       to;
   } vec_t;

   typedef struct {
      logic [1:0] who;
      logic [3:0] win;
      logic [3:0] lose;
      logic       mm;
      logic       to;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_l;
   logic       cmd_valid, cmd_valid_wd;
   logic       cmd_ready, cmd_ready_wd;
   logic [3:0] cmd_load;
   logic [1:0] cmd_ctrl;
   logic       cmd_bounce;
   logic       abort;
   logic       INIT, wd_init;
   logic [3:0] loadValue, wd_load;
   logic [1:0] ctrl, wd_ctrl;
   logic [1:0] WHO;
   logic       LOSER, WINNER, GAMEOVER;
   logic       done, wd_done;
   logic [1:0] result_who, wd_who;
   logic [3:0] win_tally, lose_tally, wd_win, wd_lose;
   logic       mismatch, timeout, wd_mismatch, wd_timeout;

   exp_t sb[$];
   vec_t vecs[6];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   counter_game_master dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_load   (cmd_load),
      .cmd_ctrl   (cmd_ctrl),
      .cmd_bounce (cmd_bounce),
      .abort      (abort),
      .INIT       (INIT),
      .loadValue  (loadValue),
      .ctrl       (ctrl),
      .WHO        (WHO),
      .LOSER      (LOSER),
      .WINNER     (WINNER),
      .GAMEOVER   (GAMEOVER),
      .done       (done),
      .result_who (result_who),
      .win_tally  (win_tally),
      .lose_tally (lose_tally),
      .mismatch   (mismatch),
      .timeout    (timeout)
   );

   // Short-watchdog instance wired to a counter that never responds.
   counter_game_master #(.TIMEOUT_CYCLES(64)) dut_wd (
      .clk        (clk),
      .rst_l      (rst_l),
      .cmd_valid  (cmd_valid_wd),
      .cmd_ready  (cmd_ready_wd),
      .cmd_load   (cmd_load),
      .cmd_ctrl   (cmd_ctrl),
      .cmd_bounce (cmd_bounce),
      .abort      (1'b0),
      .INIT       (wd_init),
      .loadValue  (wd_load),
      .ctrl       (wd_ctrl),
      .WHO        (2'b00),
      .LOSER      (1'b0),
      .WINNER     (1'b0),
      .GAMEOVER   (1'b0),
      .done       (wd_done),
      .result_who (wd_who),
      .win_tally  (wd_win),
      .lose_tally (wd_lose),
      .mismatch   (wd_mismatch),
      .timeout    (wd_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] who, input logic [3:0] win, input logic [3:0] lose,
                           input logic mm, input logic to);
      exp_t e;
      e.who = who; e.win = win; e.lose = lose; e.mm = mm; e.to = to;
      sb.push_back(e);
   endtask

   task automatic score(input string tag, input logic [1:0] who, input logic [3:0] win,
                        input logic [3:0] lose, input logic mm, input logic to);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_sb: got done, want no result pending", tag);
         return;
      end
      e = sb.pop_front();
      check({tag, "_who"},      32'(who),  32'(e.who));
      check({tag, "_win"},      32'(win),  32'(e.win));
      check({tag, "_lose"},     32'(lose), 32'(e.lose));
      check({tag, "_mismatch"}, 32'(mm),   32'(e.mm));
      check({tag, "_timeout"},  32'(to),   32'(e.to));
   endtask

   task automatic drop_and_abort();
      if (sb.size() > 0) void'(sb.pop_front());
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic clear_counter_inputs();
      LOSER = 1'b0; WINNER = 1'b0; GAMEOVER = 1'b0; WHO = 2'b00;
   endtask

   // Waits for cmd_ready, issues one command and checks the INIT cycle.
   task automatic start_cmd(input logic [3:0] load, input logic [1:0] mode, input logic bounce);
      int guard = 0;
      while (cmd_ready !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      check("wait_ready", 32'(cmd_ready), 1);
      cmd_load = load; cmd_ctrl = mode; cmd_bounce = bounce; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("init_high",  32'(INIT),      1);
      check("init_load",  32'(loadValue), 32'(load));
      check("init_ctrl",  32'(ctrl),      32'(mode));
      check("busy_ready", 32'(cmd_ready), 0);
      check("clear_tally", 32'({win_tally, lose_tally, mismatch, timeout}), 0);
   endtask

   // Plays one table game against a counter that wraps and pulses at 0 / 15.
   task automatic run_game(input vec_t v);
      int cnt, lm, wm, l, w, delta, guard;
      logic [1:0] ectrl, wdrv;
      bit g, seen, ok;
      push_exp(v.who, v.win, v.lose, v.mm, v.to);
      start_cmd(v.load, v.mode, v.bounce);
      cnt = int'(v.load); lm = 0; wm = 0; ectrl = v.mode; seen = 0; ok = 0;
      step();
      check("init_one_cycle", 32'(INIT), 0);
      for (guard = 0; guard < 600 && !seen; guard++) begin
         check("run_ctrl", 32'(ctrl), 32'(ectrl));
         l = (cnt == 0) ? 1 : 0;
         w = (cnt == 15) ? 1 : 0;
         g = (lm + l == 15) || (wm + w == 15);
         wdrv = (lm + l == 15) ? 2'b01 : ((wm + w == 15) ? 2'b10 : 2'b00);
         if (v.lie) wdrv = ~wdrv;
         LOSER = (l != 0); WINNER = (w != 0); GAMEOVER = g; WHO = g ? wdrv : 2'b00;
         lm += l; wm += w;
         case (ectrl)
            2'b00:   delta = 1;
            2'b01:   delta = 2;
            2'b10:   delta = -1;
            default: delta = -2;
         endcase
         cnt = (cnt + delta) & 15;
         if (v.bounce && (l != 0 || w != 0)) ectrl[1] = ~ectrl[1];
         step();
         clear_counter_inputs();
         if (g || done) begin
            seen = 1;
            check("done_with_gameover", 32'({g, done}), 32'(2'b11));
            if (done) begin
               ok = 1;
               score("game", result_who, win_tally, lose_tally, mismatch, timeout);
               check("report_ctrl", 32'(ctrl), 32'(ectrl));
            end else begin
               drop_and_abort();
            end
         end
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL game_budget: got no done, want done within 600 cycles");
         drop_and_abort();
      end else if (ok) begin
         step();
         check("done_one_cycle", 32'(done),       0);
         check("ready_after",    32'(cmd_ready),  1);
         check("who_holds",      32'(result_who), 32'(v.who));
      end
   endtask

   initial begin
      int runc;
      vecs[0] = '{4'd0,  2'b00, 1'b0, 1'b0, 2'b01, 4'd14, 4'd15, 1'b0, 1'b0};
      vecs[1] = '{4'd15, 2'b10, 1'b0, 1'b0, 2'b10, 4'd15, 4'd14, 1'b0, 1'b0};
      vecs[2] = '{4'd0,  2'b00, 1'b1, 1'b0, 2'b01, 4'd13, 4'd15, 1'b0, 1'b0};
      vecs[3] = '{4'd0,  2'b01, 1'b0, 1'b0, 2'b01, 4'd0,  4'd15, 1'b0, 1'b0};
      vecs[4] = '{4'd15, 2'b11, 1'b0, 1'b0, 2'b10, 4'd15, 4'd0,  1'b0, 1'b0};
      vecs[5] = '{4'd0,  2'b00, 1'b0, 1'b1, 2'b10, 4'd14, 4'd15, 1'b1, 1'b0};

      cmd_valid = 1'b0; cmd_valid_wd = 1'b0; cmd_load = '0; cmd_ctrl = '0; cmd_bounce = 1'b0;
      abort = 1'b0;
      clear_counter_inputs();
      rst_l = 1'b1;
      #3;
      check("reset_outputs", 32'({INIT, loadValue, ctrl, done, result_who, win_tally,
                                  lose_tally, mismatch, timeout}), 0);
      check("reset_ready", 32'(cmd_ready), 1);
      #10 rst_l = 1'b0;
      step();

      for (int i = 0; i < 6; i++) run_game(vecs[i]);

      // Tally saturation: 17 LOSER pulses then GAMEOVER with a consistent WHO.
      push_exp(2'b01, 4'd0, 4'd15, 1'b0, 1'b0);
      start_cmd(4'd4, 2'b00, 1'b0);
      step();
      LOSER = 1'b1;
      for (int i = 0; i < 17; i++) step();
      LOSER = 1'b0;
      check("sat_lose", 32'(lose_tally), 15);
      GAMEOVER = 1'b1; WHO = 2'b01;
      step();
      clear_counter_inputs();
      check("sat_done", 32'(done), 1);
      score("sat", result_who, win_tally, lose_tally, mismatch, timeout);

      // LOSER and WINNER together flag a protocol error.
      push_exp(2'b00, 4'd1, 4'd1, 1'b1, 1'b0);
      step();
      start_cmd(4'd5, 2'b01, 1'b0);
      step();
      LOSER = 1'b1; WINNER = 1'b1;
      step();
      clear_counter_inputs();
      GAMEOVER = 1'b1; WHO = 2'b00;
      step();
      clear_counter_inputs();
      check("both_done", 32'(done), 1);
      score("both", result_who, win_tally, lose_tally, mismatch, timeout);

      // Abort outranks a simultaneous GAMEOVER and freezes results.
      step();
      start_cmd(4'd9, 2'b11, 1'b0);
      step();
      LOSER = 1'b1;
      step();
      LOSER = 1'b0;
      check("abort_pre_lose", 32'(lose_tally), 1);
      abort = 1'b1; LOSER = 1'b1; GAMEOVER = 1'b1; WHO = 2'b01;
      step();
      abort = 1'b0;
      clear_counter_inputs();
      check("abort_no_done", 32'(done),       0);
      check("abort_ready",   32'(cmd_ready),  1);
      check("abort_frozen",  32'(lose_tally), 1);
      check("abort_who",     32'(result_who), 0);
      step();
      check("abort_late_done", 32'(done), 0);
      start_cmd(4'd3, 2'b01, 1'b0);

      // Asynchronous reset between edges while a game runs.
      step();
      LOSER = 1'b1;
      step();
      LOSER = 1'b0;
      check("pre_reset_lose", 32'(lose_tally), 1);
      #2 rst_l = 1'b1;
      #1;
      check("async_reset_outputs", 32'({INIT, loadValue, ctrl, done, result_who, win_tally,
                                        lose_tally, mismatch, timeout}), 0);
      check("async_reset_ready", 32'(cmd_ready), 1);
      #1 rst_l = 1'b0;
      step();

      // Watchdog on the short-timeout instance.
      cmd_load = 4'd7; cmd_ctrl = 2'b10; cmd_bounce = 1'b0; cmd_valid_wd = 1'b1;
      push_exp(2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
      step();
      cmd_valid_wd = 1'b0;
      check("wd_init", 32'(wd_init), 1);
      runc = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (wd_done) break;
         runc++;
      end
      check("wd_run_cycles", 32'(runc), 64);
      check("wd_done", 32'(wd_done), 1);
      score("wd", wd_who, wd_win, wd_lose, wd_mismatch, wd_timeout);
      step();
      check("wd_done_one_cycle", 32'(wd_done), 0);
      check("sb_empty", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
